// File: rtl/axi4_lite_manager_pkg.sv
// Shared types and AXI constants for the AXI4-Lite manager.
package axi4_lite_manager_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    WR_RESP,
    RD_ADDR,
    RD_DATA,
    RSP,
    DRAIN
  } state_t;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  localparam logic [2:0] PROT_DEFAULT = 3'b000;

endpackage

// File: rtl/axi4_lite.sv
// AXI4-Lite bus bundle; m is the manager view, s the subordinate view.
interface axi4_lite #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic                     aresetn;
  logic                     ack;
  logic                     awvalid;
  logic                     awready;
  logic [ADDRESS_WIDTH-1:0] awaddr;
  logic [2:0]               awprot;
  logic                     wvalid;
  logic                     wready;
  logic [DATA_WIDTH-1:0]    wdata;
  logic [STRB_WIDTH-1:0]    wstrb;
  logic                     bvalid;
  logic                     bready;
  logic [1:0]               bresp;
  logic                     arvalid;
  logic                     arready;
  logic [ADDRESS_WIDTH-1:0] araddr;
  logic [2:0]               arprot;
  logic                     rvalid;
  logic                     rready;
  logic [DATA_WIDTH-1:0]    rdata;
  logic [1:0]               rresp;

  modport m (
    input  aresetn, ack, awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp,
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready, arvalid, araddr, arprot, rready
  );

  modport s (
    input  aresetn, ack, awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready, arvalid, araddr,
           arprot, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

endinterface

// File: rtl/axi4_lite_manager.sv
// Single-outstanding AXI4-Lite manager: one cmd_* request becomes one AXI transaction and one rsp_*.
// Define AXI4_LITE_MANAGER_TIMEOUT_EN to add the response watchdog and the DRAIN recovery path.
module axi4_lite_manager
  import axi4_lite_manager_pkg::*;
#(
  parameter int  ADDRESS_WIDTH  = 32,
  parameter int  DATA_WIDTH     = 32,
  parameter int  TIMEOUT_CYCLES = 256,
  localparam int STRB_WIDTH     = DATA_WIDTH / 8
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_we,
  input  logic [ADDRESS_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0]    cmd_wdata,
  input  logic [STRB_WIDTH-1:0]    cmd_wstrb,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic                     rsp_we,
  output logic [DATA_WIDTH-1:0]    rsp_rdata,
  output logic [1:0]               rsp_resp,
  output logic                     rsp_timeout,
  axi4_lite.m                      bus
);

  state_t                   state;
  logic                     we_q;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0]    wdata_q;
  logic [STRB_WIDTH-1:0]    wstrb_q;
  logic                     awvalid_q, wvalid_q, arvalid_q, bready_q, rready_q;
  logic                     aw_done, w_done;

  assign aw_done = !awvalid_q || bus.awready;
  assign w_done  = !wvalid_q || bus.wready;

  assign bus.awvalid = awvalid_q;
  assign bus.awaddr  = addr_q;
  assign bus.awprot  = PROT_DEFAULT;
  assign bus.wvalid  = wvalid_q;
  assign bus.wdata   = wdata_q;
  assign bus.wstrb   = wstrb_q;
  assign bus.bready  = bready_q;
  assign bus.arvalid = arvalid_q;
  assign bus.araddr  = addr_q;
  assign bus.arprot  = PROT_DEFAULT;
  assign bus.rready  = rready_q;

`ifdef AXI4_LITE_MANAGER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt;
  logic             need_b, need_r, timeout_q, busy;

  assign busy        = (state == WR) || (state == WR_RESP) || (state == RD_ADDR) || (state == RD_DATA);
  assign rsp_timeout = timeout_q;
`else
  assign rsp_timeout = 1'b0;
`endif

  always_ff @(posedge aclk) begin
    if (areset) begin
      state     <= IDLE;
      cmd_ready <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      bready_q  <= 1'b0;
      rready_q  <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_we    <= 1'b0;
      rsp_rdata <= '0;
      rsp_resp  <= OKAY;
`ifdef AXI4_LITE_MANAGER_TIMEOUT_EN
      cnt       <= '0;
      need_b    <= 1'b0;
      need_r    <= 1'b0;
      timeout_q <= 1'b0;
`endif
    end else begin
      // Each channel releases its valid/ready on its own handshake, whatever the state.
      if (awvalid_q && bus.awready) awvalid_q <= 1'b0;
      if (wvalid_q && bus.wready)   wvalid_q  <= 1'b0;
      if (arvalid_q && bus.arready) arvalid_q <= 1'b0;
      if (bready_q && bus.bvalid)   bready_q  <= 1'b0;
      if (rready_q && bus.rvalid)   rready_q  <= 1'b0;
`ifdef AXI4_LITE_MANAGER_TIMEOUT_EN
      if (bready_q && bus.bvalid) need_b <= 1'b0;
      if (rready_q && bus.rvalid) need_r <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            we_q      <= cmd_we;
            addr_q    <= cmd_addr;
            wdata_q   <= cmd_wdata;
            wstrb_q   <= cmd_wstrb;
`ifdef AXI4_LITE_MANAGER_TIMEOUT_EN
            need_b    <= cmd_we;
            need_r    <= !cmd_we;
`endif
            if (cmd_we) begin
              state     <= WR;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
            end else begin
              state     <= RD_ADDR;
              arvalid_q <= 1'b1;
            end
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        WR: begin
          if (aw_done && w_done) begin
            state    <= WR_RESP;
            bready_q <= 1'b1;
          end
        end
        WR_RESP: begin
          if (bus.bvalid) begin
            state     <= RSP;
            rsp_valid <= 1'b1;
            rsp_we    <= 1'b1;
            rsp_resp  <= bus.bresp;
            rsp_rdata <= '0;
          end
        end
        RD_ADDR: begin
          if (bus.arready) begin
            state    <= RD_DATA;
            rready_q <= 1'b1;
          end
        end
        RD_DATA: begin
          if (bus.rvalid) begin
            state     <= RSP;
            rsp_valid <= 1'b1;
            rsp_we    <= 1'b0;
            rsp_resp  <= bus.rresp;
            rsp_rdata <= bus.rdata;
          end
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
`ifdef AXI4_LITE_MANAGER_TIMEOUT_EN
            timeout_q <= 1'b0;
            if (timeout_q) begin
              state <= DRAIN;
            end else begin
              state     <= IDLE;
              cmd_ready <= 1'b1;
            end
`else
            state     <= IDLE;
            cmd_ready <= 1'b1;
`endif
          end
        end
        DRAIN: begin
`ifdef AXI4_LITE_MANAGER_TIMEOUT_EN
          // Absorb the late response once its request side has fully handshaken.
          if (need_b && !awvalid_q && !wvalid_q && !bready_q) bready_q <= 1'b1;
          if (need_r && !arvalid_q && !rready_q) rready_q <= 1'b1;
          if (!need_b && !need_r) state <= IDLE;
`else
          state <= IDLE;
`endif
        end
        default: state <= IDLE;
      endcase
`ifdef AXI4_LITE_MANAGER_TIMEOUT_EN
      if (busy) begin
        cnt <= cnt + 1'b1;
        if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state     <= RSP;
          rsp_valid <= 1'b1;
          rsp_we    <= we_q;
          rsp_rdata <= '0;
          rsp_resp  <= SLVERR;
          timeout_q <= 1'b1;
        end
      end else begin
        cnt <= '0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_axi4_lite_manager.sv
// Directed bench for axi4_lite_manager with a response scoreboard.
// Define AXI4_LITE_MANAGER_TIMEOUT_EN to also exercise the watchdog with TIMEOUT_CYCLES=8.
module tb_axi4_lite_manager;
  import axi4_lite_manager_pkg::*;

  typedef struct packed {
    logic        we;
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic        to;
  } rsp_t;

  logic        clk = 1'b0;
  logic        areset;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_we, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;

  int vectors = 0;
  int miscompares = 0;
  int aw_hs = 0, w_hs = 0, ar_hs = 0, b_hs = 0, r_hs = 0, rsp_hs = 0;
  int aw0, w0, ar0, b0, r0, rsp0, n;
  logic [31:0] aw_addr_seen, w_data_seen, ar_addr_seen;
  logic [3:0]  w_strb_seen;
  rsp_t exp_q[$];
  rsp_t e;

  always #5 clk = ~clk;

  axi4_lite #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) bus ();

  axi4_lite_manager #(
    .ADDRESS_WIDTH (32),
    .DATA_WIDTH    (32),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .aclk       (clk),
    .areset     (areset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_we     (cmd_we),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .cmd_wstrb  (cmd_wstrb),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_we     (rsp_we),
    .rsp_rdata  (rsp_rdata),
    .rsp_resp   (rsp_resp),
    .rsp_timeout(rsp_timeout),
    .bus        (bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int cycles);
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Offer a command, wait (bounded) for acceptance; returns 1 time unit into the cycle after accept.
  task automatic send_cmd(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, input logic push, input rsp_t exp);
    int k = 0;
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    cmd_wstrb = strb;
    if (push) exp_q.push_back(exp);
    @(negedge clk);
    while (!cmd_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!cmd_ready) check("cmd_accept", 64'(cmd_ready), 64'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_b(input int start, input int lim);
    int k = 0;
    while (b_hs == start && k < lim) begin
      tick(1);
      k++;
    end
    if (b_hs == start) check("b_hs_wait", 64'(b_hs), 64'(start + 1));
  endtask

  // Observe bus handshakes and score responses in the middle of each cycle.
  always @(negedge clk) begin
    if (!areset) begin
      if (bus.awvalid && bus.awready) begin
        aw_hs++;
        aw_addr_seen = bus.awaddr;
      end
      if (bus.wvalid && bus.wready) begin
        w_hs++;
        w_data_seen = bus.wdata;
        w_strb_seen = bus.wstrb;
      end
      if (bus.arvalid && bus.arready) begin
        ar_hs++;
        ar_addr_seen = bus.araddr;
      end
      if (bus.bvalid && bus.bready) b_hs++;
      if (bus.rvalid && bus.rready) r_hs++;
      if (rsp_valid && rsp_ready) begin
        rsp_hs++;
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", 64'(exp_q.size()), 64'd1);
        end else begin
          e = exp_q.pop_front();
          check("rsp_we", 64'(rsp_we), 64'(e.we));
          check("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
          check("rsp_resp", 64'(rsp_resp), 64'(e.resp));
          check("rsp_timeout", 64'(rsp_timeout), 64'(e.to));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    areset = 1'b1;  cmd_valid = 1'b0; cmd_we = 1'b0;  cmd_addr = '0;
    cmd_wdata = '0; cmd_wstrb = '0;   rsp_ready = 1'b1;
    bus.ack = 1'b0;     bus.aresetn = 1'b1; bus.awready = 1'b0; bus.wready = 1'b0;
    bus.bvalid = 1'b0;  bus.bresp = 2'b00;  bus.arready = 1'b0; bus.rvalid = 1'b0;
    bus.rdata = '0;     bus.rresp = 2'b00;

    // Reset state
    tick(3);
    @(negedge clk);
    check("rst_ctrl", 64'({cmd_ready, rsp_valid, rsp_timeout, bus.awvalid, bus.wvalid,
                           bus.arvalid, bus.bready, bus.rready}), 64'h0);
    check("rst_rsp", 64'({rsp_we, rsp_resp, rsp_rdata}), 64'h0);
    check("rst_prot", 64'({bus.awprot, bus.arprot}), 64'h0);
    tick(1);
    areset = 1'b0;

    // Simple write, both ready, B one cycle after AW/W
    aw0 = aw_hs; w0 = w_hs; b0 = b_hs;
    bus.awready = 1'b1; bus.wready = 1'b1;
    send_cmd(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b1, {1'b1, 32'h0, OKAY, 1'b0});
    tick(1);
    bus.bvalid = 1'b1; bus.bresp = OKAY;
    tick(1);
    bus.bvalid = 1'b0;
    @(negedge clk);
    check("wr_latency", 64'(rsp_valid), 64'd1);
    tick(2);
    bus.awready = 1'b0; bus.wready = 1'b0;
    check("wr_aw_count", 64'(aw_hs - aw0), 64'd1);
    check("wr_w_count", 64'(w_hs - w0), 64'd1);
    check("wr_b_count", 64'(b_hs - b0), 64'd1);
    check("wr_awaddr", 64'(aw_addr_seen), 64'h10);
    check("wr_wdata", 64'(w_data_seen), 64'hDEADBEEF);
    check("wr_wstrb", 64'(w_strb_seen), 64'hF);

    // Write with wready four cycles ahead of awready
    aw0 = aw_hs; w0 = w_hs; b0 = b_hs;
    send_cmd(1'b1, 32'h44, 32'hA5A50F0F, 4'h3, 1'b1, {1'b1, 32'h0, EXOKAY, 1'b0});
    bus.wready = 1'b1;
    tick(1);
    bus.wready = 1'b0;
    tick(1);
    @(negedge clk);
    check("skew_wvalid_dropped", 64'(bus.wvalid), 64'd0);
    check("skew_awvalid_held", 64'(bus.awvalid), 64'd1);
    check("skew_awaddr_stable", 64'(bus.awaddr), 64'h44);
    tick(2);
    bus.awready = 1'b1;
    tick(1);
    bus.awready = 1'b0; bus.bvalid = 1'b1; bus.bresp = EXOKAY;
    tick(1);
    bus.bvalid = 1'b0;
    tick(3);
    check("skew_aw_count", 64'(aw_hs - aw0), 64'd1);
    check("skew_w_count", 64'(w_hs - w0), 64'd1);
    check("skew_b_count", 64'(b_hs - b0), 64'd1);
    check("skew_wdata", 64'({w_strb_seen, w_data_seen}), 64'h3A5A50F0F);

    // Read with SLVERR response
    ar0 = ar_hs; r0 = r_hs;
    bus.arready = 1'b1;
    send_cmd(1'b0, 32'h20, 32'h0, 4'h0, 1'b1, {1'b0, 32'h12345678, SLVERR, 1'b0});
    tick(1);
    bus.arready = 1'b0; bus.rvalid = 1'b1; bus.rdata = 32'h12345678; bus.rresp = SLVERR;
    tick(1);
    bus.rvalid = 1'b0;
    @(negedge clk);
    check("rd_latency", 64'(rsp_valid), 64'd1);
    tick(2);
    check("rd_araddr", 64'(ar_addr_seen), 64'h20);
    check("rd_ar_count", 64'(ar_hs - ar0), 64'd1);
    check("rd_r_count", 64'(r_hs - r0), 64'd1);

    // Response back-pressure with the next command already offered
    rsp_ready = 1'b0;
    bus.arready = 1'b1;
    send_cmd(1'b0, 32'h30, 32'h0, 4'h0, 1'b1, {1'b0, 32'hCAFEF00D, OKAY, 1'b0});
    tick(1);
    bus.arready = 1'b0; bus.rvalid = 1'b1; bus.rdata = 32'hCAFEF00D; bus.rresp = OKAY;
    tick(1);
    bus.rvalid = 1'b0;
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 32'h50; cmd_wdata = 32'h0BADF00D; cmd_wstrb = 4'hC;
    exp_q.push_back({1'b1, 32'h0, DECERR, 1'b0});
    bus.awready = 1'b1; bus.wready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_rsp_valid", 64'(rsp_valid), 64'd1);
      check("stall_rsp_fields", 64'({rsp_we, rsp_resp, rsp_rdata}), 64'({1'b0, OKAY, 32'hCAFEF00D}));
      check("stall_cmd_ready", 64'(cmd_ready), 64'd0);
      tick(1);
    end
    rsp_ready = 1'b1;
    bus.bvalid = 1'b1; bus.bresp = DECERR;
    b0 = b_hs;
    @(negedge clk);
    check("stall_no_early_accept", 64'(cmd_ready), 64'd0);
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) check("stall_held_cmd_accept", 64'(cmd_ready), 64'd1);
    tick(1);
    cmd_valid = 1'b0;
    wait_b(b0, 10);
    bus.bvalid = 1'b0;
    tick(2);
    bus.awready = 1'b0; bus.wready = 1'b0;
    check("stall_awaddr", 64'(aw_addr_seen), 64'h50);
    check("stall_b_count", 64'(b_hs - b0), 64'd1);

    // Reset while waiting for read data
    rsp0 = rsp_hs;
    bus.arready = 1'b1;
    send_cmd(1'b0, 32'h60, 32'h0, 4'h0, 1'b0, {1'b0, 32'h0, OKAY, 1'b0});
    tick(1);
    areset = 1'b1; bus.arready = 1'b0;
    @(negedge clk);
    check("mid_rd_rready", 64'(bus.rready), 64'd1);
    tick(1);
    areset = 1'b0;
    @(negedge clk);
    check("mid_rst_ctrl", 64'({cmd_ready, rsp_valid, rsp_timeout, bus.awvalid, bus.wvalid,
                               bus.arvalid, bus.bready, bus.rready}), 64'h0);
    check("mid_rst_state", 64'(dut.state), 64'(IDLE));
    check("mid_rst_rsp", 64'({rsp_we, rsp_resp, rsp_rdata}), 64'h0);
    tick(4);
    check("mid_rst_no_rsp", 64'(rsp_hs - rsp0), 64'd0);
    check("mid_rst_cmd_ready", 64'(cmd_ready), 64'd1);

`ifdef AXI4_LITE_MANAGER_TIMEOUT_EN
    // Withheld write response times out, late B is absorbed silently
    b0 = b_hs;
    bus.awready = 1'b1; bus.wready = 1'b1;
    send_cmd(1'b1, 32'h70, 32'h11112222, 4'hF, 1'b1, {1'b1, 32'h0, SLVERR, 1'b1});
    rsp0 = rsp_hs;
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("to_rsp_valid", 64'(rsp_valid), 64'd1);
    tick(3);
    bus.awready = 1'b0; bus.wready = 1'b0;
    check("to_cmd_ready_in_drain", 64'(cmd_ready), 64'd0);
    bus.bvalid = 1'b1; bus.bresp = OKAY;
    wait_b(b0, 10);
    bus.bvalid = 1'b0;
    tick(5);
    check("to_single_rsp", 64'(rsp_hs - rsp0), 64'd1);
    check("to_b_count", 64'(b_hs - b0), 64'd1);
    check("to_back_to_idle", 64'(cmd_ready), 64'd1);
`endif

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
